inst_fetch_queue: RTL

Instruction fetch front-end between the word-addressed instruction memory and the CPU decode stage. Holds the fetch PC and drives the memory address. Captures the combinational instruction word into a small FIFO of {pc, inst} entries and hands them to decode over a valid/ready handshake. A redirect input (taken branch/jump from execute) flushes the queue and restarts fetch at a new PC.

---
 rtl/ifq_pkg.sv | 16 +
 rtl/inst_fetch_queue_if.sv | 45 ++++
 rtl/ifq_fifo.sv | 55 +++++
 rtl/inst_fetch_queue.sv | 65 ++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and defaults for the instruction fetch queue
package ifq_pkg;

    localparam int unsigned IFQ_ADDR_W = 32;
    localparam int unsigned IFQ_DATA_W = 32;

    // Fetch PC after reset and the instruction word shown when the queue is empty
    localparam logic [IFQ_ADDR_W-1:0] IFQ_RESET_PC = '0;
    localparam logic [IFQ_DATA_W-1:0] IFQ_NOP      = 32'h0000_0000;

    typedef struct packed {
        logic [IFQ_ADDR_W-1:0] pc;
        logic [IFQ_DATA_W-1:0] inst;
    } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - memory, decode and redirect signals of the fetch queue
interface inst_fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_inst;
    logic              out_valid;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic [CNT_W-1:0]  count;

    // Fetch queue side
    modport master (
        output imem_addr,
        input  imem_inst,
        output out_valid,
        output out_inst,
        output out_pc,
        input  out_ready,
        input  redirect_valid,
        input  redirect_pc,
        output count
    );

    // Memory / decode / execute side
    modport slave (
        input  imem_addr,
        output imem_inst,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        output out_ready,
        output redirect_valid,
        output redirect_pc,
        input  count
    );

endinterface

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - generic synchronous FIFO with flush, count and head data
module ifq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the FIFO without touching storage
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - fetch PC owner feeding {pc, inst} entries to decode
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC),
    parameter logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(1)
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.master ifq
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [CNT_W-1:0]         fifo_count;

    assign ifq.imem_addr = fetch_pc;

    // A redirect voids any handshake at the head and suppresses the fetch of the stale path
    assign pop  = ~empty & ifq.out_ready & ~ifq.redirect_valid;
    assign push = (~full | pop) & ~ifq.redirect_valid;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (ifq.redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata ({fetch_pc, ifq.imem_inst}),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Head is masked so decode never sees stale storage while the queue is empty
    assign ifq.out_valid = ~empty;
    assign ifq.out_pc    = empty ? '0 : head[DATA_W +: ADDR_W];
    assign ifq.out_inst  = empty ? DATA_W'(IFQ_NOP) : head[DATA_W-1:0];
    assign ifq.count     = fifo_count;

    // Fetch PC: restart on reset or redirect, otherwise advance once per accepted fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (ifq.redirect_valid) begin
            fetch_pc <= ifq.redirect_pc;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

endmodule
